// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-access SRAM controller: IDLE -> ISSUE -> WAIT.
// Define SRAM_ARBITER_FIXED_PRIORITY_EN to make port 0 always win (default: round-robin).
module sram_arbiter #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_completed
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_t;

    state_t state_q, state_d;
    logic   sel_q;
    logic   we_q;
    logic   any_req, pick1;
    logic   gnt0_d, gnt1_d, done0_d, done1_d, wr_en_d, rd_en_d;

`ifndef SRAM_ARBITER_FIXED_PRIORITY_EN
    logic   last_q;  // 1: port 1 was served last
`endif

    always_comb begin
        any_req = req0 | req1;
`ifdef SRAM_ARBITER_FIXED_PRIORITY_EN
        pick1 = ~req0;
`else
        pick1 = req1 & (~req0 | ~last_q);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (mem_completed) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic; pulses are computed here and registered below
    always_comb begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (any_req) begin
                    gnt0_d = ~pick1;
                    gnt1_d = pick1;
                end
            end
            StIssue: begin
                wr_en_d = we_q;
                rd_en_d = ~we_q;
            end
            StWait: begin
                if (mem_completed) begin
                    done0_d = ~sel_q;
                    done1_d = sel_q;
                end
            end
            default: ;
        endcase
        busy = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
`ifndef SRAM_ARBITER_FIXED_PRIORITY_EN
            last_q    <= 1'b1;
`endif
        end else begin
            gnt0      <= gnt0_d;
            gnt1      <= gnt1_d;
            done0     <= done0_d;
            done1     <= done1_d;
            mem_wr_en <= wr_en_d;
            mem_rd_en <= rd_en_d;
            if (state_q == StIdle && any_req) begin
                sel_q     <= pick1;
                we_q      <= pick1 ? we1 : we0;
                mem_addr  <= pick1 ? addr1 : addr0;
                mem_wdata <= pick1 ? wdata1 : wdata0;
            end
            if (state_q == StWait && mem_completed) begin
                if (!we_q && sel_q)  rdata1 <= mem_rdata;
                if (!we_q && !sel_q) rdata0 <= mem_rdata;
`ifndef SRAM_ARBITER_FIXED_PRIORITY_EN
                last_q <= sel_q;
`endif
            end
        end
    end

endmodule
